// File: rtl/matrix_result_streamer_pkg.sv
// Shared constants and types for the matrix result path.
// The multiplication ALU and its loaders reuse the same geometry and state encoding.
package matrix_result_streamer_pkg;

  localparam int MAT_ROWS   = 5;
  localparam int MAT_COLS   = 5;
  localparam int MAT_ELEM_W = 8;
  localparam int MAT_W      = MAT_ROWS * MAT_COLS * MAT_ELEM_W;
  localparam int IDX_W      = 3;
  localparam int NUM_ELEMS  = MAT_ROWS * MAT_COLS;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Bit offset of element (r,c) inside a row-major flattened matrix.
  function automatic int elem_lsb(input int r, input int c, input int cols, input int elem_w);
    return (r * cols * elem_w) + (c * elem_w);
  endfunction

endpackage

// File: rtl/matrix_element_select.sv
// Combinational (row,col) -> element mux over a row-major flattened matrix.
// Out-of-range indices return zero rather than an arbitrary slice.
module matrix_element_select
  import matrix_result_streamer_pkg::*;
#(
  parameter int ROWS   = MAT_ROWS,
  parameter int COLS   = MAT_COLS,
  parameter int ELEM_W = MAT_ELEM_W
) (
  input  logic [ROWS*COLS*ELEM_W-1:0] matrix,
  input  logic [IDX_W-1:0]            row,
  input  logic [IDX_W-1:0]            col,
  output logic [ELEM_W-1:0]           elem
);

  localparam int FLAT_W = ROWS * COLS * ELEM_W;
  localparam int SEL_W  = $clog2(FLAT_W);

  logic [SEL_W-1:0] lsb_s;

  // Pick the addressed element; indices outside the matrix yield zero.
  always_comb begin
    lsb_s = '0;
    elem  = '0;
    if ((int'(row) < ROWS) && (int'(col) < COLS)) begin
      lsb_s = SEL_W'(elem_lsb(int'(row), int'(col), COLS, ELEM_W));
      elem  = matrix[lsb_s +: ELEM_W];
    end else begin
      lsb_s = '0;
      elem  = '0;
    end
  end

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a finished matrix into a shadow register and streams its elements
// in row-major order over a valid/ready interface. All outputs are registered:
// the next element is selected from the next-cycle shadow and indices, so the
// first element is available the cycle after capture without a bubble.
module matrix_result_streamer
  import matrix_result_streamer_pkg::*;
#(
  parameter int ROWS   = MAT_ROWS,
  parameter int COLS   = MAT_COLS,
  parameter int ELEM_W = MAT_ELEM_W
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ROWS*COLS*ELEM_W-1:0] matrix_flat,
  input  logic                        overflow_in,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [ELEM_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_row,
  output logic [IDX_W-1:0]            out_col,
  output logic                        out_last,
  output logic                        out_overflow,
  output logic                        busy,
  output logic                        finished,
  output logic                        start_ignored
);

  localparam int FLAT_W = ROWS * COLS * ELEM_W;
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

  state_t              state_r;
  logic [IDX_W-1:0]    row_r;
  logic [IDX_W-1:0]    col_r;
  logic [FLAT_W-1:0]   shadow_r;

  state_t              state_nxt_s;
  logic [IDX_W-1:0]    row_nxt_s;
  logic [IDX_W-1:0]    col_nxt_s;
  logic [FLAT_W-1:0]   shadow_nxt_s;
  logic                capture_s;
  logic                hs_s;
  logic                last_hs_s;
  logic                send_nxt_s;
  logic                last_nxt_s;
  logic [ELEM_W-1:0]   elem_s;

  // Next-state, next-index and shadow-load decisions for the coming edge.
  always_comb begin
    capture_s    = (state_r == ST_IDLE) && start;
    hs_s         = (state_r == ST_SEND) && out_valid && out_ready;
    last_hs_s    = hs_s && out_last;
    state_nxt_s  = state_r;
    row_nxt_s    = row_r;
    col_nxt_s    = col_r;
    shadow_nxt_s = shadow_r;
    if (capture_s) begin
      state_nxt_s  = ST_SEND;
      row_nxt_s    = '0;
      col_nxt_s    = '0;
      shadow_nxt_s = matrix_flat;
    end else if (last_hs_s) begin
      state_nxt_s  = ST_IDLE;
      row_nxt_s    = '0;
      col_nxt_s    = '0;
    end else if (hs_s) begin
      if (col_r == LAST_COL) begin
        col_nxt_s = '0;
        row_nxt_s = row_r + IDX_W'(1);
      end else begin
        col_nxt_s = col_r + IDX_W'(1);
        row_nxt_s = row_r;
      end
    end else begin
      state_nxt_s = state_r;
    end
    send_nxt_s = (state_nxt_s == ST_SEND);
    last_nxt_s = send_nxt_s && (row_nxt_s == LAST_ROW) && (col_nxt_s == LAST_COL);
  end

  matrix_element_select #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .ELEM_W (ELEM_W)
  ) u_select (
    .matrix (shadow_nxt_s),
    .row    (row_nxt_s),
    .col    (col_nxt_s),
    .elem   (elem_s)
  );

  // Streaming FSM: state, indices, shadow capture and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      row_r         <= '0;
      col_r         <= '0;
      shadow_r      <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_row       <= '0;
      out_col       <= '0;
      out_last      <= 1'b0;
      out_overflow  <= 1'b0;
      busy          <= 1'b0;
      finished      <= 1'b0;
      start_ignored <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      row_r         <= row_nxt_s;
      col_r         <= col_nxt_s;
      shadow_r      <= shadow_nxt_s;
      out_valid     <= send_nxt_s;
      busy          <= send_nxt_s;
      out_data      <= send_nxt_s ? elem_s : '0;
      out_row       <= send_nxt_s ? row_nxt_s : '0;
      out_col       <= send_nxt_s ? col_nxt_s : '0;
      out_last      <= last_nxt_s;
      out_overflow  <= capture_s ? overflow_in : out_overflow;
      finished      <= last_hs_s;
      start_ignored <= start && (state_r == ST_SEND);
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer with a per-cycle reference model.
module tb_matrix_result_streamer;
  import matrix_result_streamer_pkg::*;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [MAT_W-1:0] matrix_flat;
  logic             overflow_in;
  logic             out_ready;
  logic             out_valid;
  logic [7:0]       out_data;
  logic [2:0]       out_row;
  logic [2:0]       out_col;
  logic             out_last;
  logic             out_overflow;
  logic             busy;
  logic             finished;
  logic             start_ignored;

  int total;
  int bad;

  // Reference model: captured matrix as an element list and a stream position.
  bit         m_active;
  int         m_k;
  logic [7:0] m_mat [NUM_ELEMS];
  bit         m_ovf;
  bit         m_fin;
  bit         m_ign;

  logic [MAT_W-1:0] mat;

  matrix_result_streamer #(
    .ROWS   (5),
    .COLS   (5),
    .ELEM_W (8)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .matrix_flat   (matrix_flat),
    .overflow_in   (overflow_in),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_row       (out_row),
    .out_col       (out_col),
    .out_last      (out_last),
    .out_overflow  (out_overflow),
    .busy          (busy),
    .finished      (finished),
    .start_ignored (start_ignored)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Drain the current stream with ready held high, bounded in cycles.
  task automatic run_out();
    bit seen;
    seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!seen) begin
        tick();
        if (finished) seen = 1'b1;
      end
    end
    check("finish_seen", int'(seen), 1);
  endtask

  // Model update from the inputs seen at each rising edge.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_ovf    <= 1'b0;
      m_fin    <= 1'b0;
      m_ign    <= 1'b0;
    end else begin
      m_fin <= 1'b0;
      m_ign <= 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active <= 1'b1;
          m_k      <= 0;
          m_ovf    <= overflow_in;
          for (int i = 0; i < NUM_ELEMS; i++) m_mat[i] <= matrix_flat[i*8 +: 8];
        end
      end else begin
        if (start) m_ign <= 1'b1;
        if (out_ready) begin
          if (m_k == NUM_ELEMS - 1) begin
            m_active <= 1'b0;
            m_fin    <= 1'b1;
          end else begin
            m_k <= m_k + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    check("valid", int'(out_valid), int'(m_active));
    check("busy", int'(busy), int'(m_active));
    check("finished", int'(finished), int'(m_fin));
    check("start_ignored", int'(start_ignored), int'(m_ign));
    check("overflow", int'(out_overflow), int'(m_ovf));
    check("last", int'(out_last), int'(m_active && (m_k == NUM_ELEMS - 1)));
    if (m_active) begin
      check("data", int'(out_data), int'(m_mat[m_k]));
      check("row", int'(out_row), m_k / 5);
      check("col", int'(out_col), m_k % 5);
    end
  end

  initial begin
    total = 0;
    bad = 0;
    start = 1'b0;
    out_ready = 1'b0;
    overflow_in = 1'b0;
    matrix_flat = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_overflow", int'(out_overflow), 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Ascending matrix, ready always high, input changes after capture.
    for (int k = 0; k < NUM_ELEMS; k++) mat[k*8 +: 8] = 8'(k);
    matrix_flat = mat;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    matrix_flat = '1;
    check("t1_first_row", int'(out_row), 0);
    check("t1_first_col", int'(out_col), 0);
    for (int i = 0; i < NUM_ELEMS; i++) begin
      check("t1_data", int'(out_data), i);
      check("t1_last", int'(out_last), (i == 24) ? 1 : 0);
      tick();
    end
    check("t1_finished", int'(finished), 1);
    check("t1_valid_end", int'(out_valid), 0);
    check("t1_busy_end", int'(busy), 0);

    // Extreme values; start issued in the finished cycle.
    for (int k = 0; k < NUM_ELEMS; k++) mat[k*8 +: 8] = 8'(k);
    mat[7:0] = 8'h80;
    mat[199:192] = 8'h7F;
    matrix_flat = mat;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t2_valid", int'(out_valid), 1);
    check("t2_first", int'($signed(out_data)), -128);
    repeat (24) tick();
    check("t2_lastval", int'($signed(out_data)), 127);
    check("t2_lastflag", int'(out_last), 1);
    tick();
    check("t2_finished", int'(finished), 1);

    // Back-pressure at element (2,3).
    for (int k = 0; k < NUM_ELEMS; k++) mat[k*8 +: 8] = 8'(k * 7 + 3);
    matrix_flat = mat;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("t3_hold_data", int'(out_data), 94);
      check("t3_hold_row", int'(out_row), 2);
      check("t3_hold_col", int'(out_col), 3);
      tick();
    end
    out_ready = 1'b1;
    check("t3_still", int'(out_data), 94);
    tick();
    check("t3_next_data", int'(out_data), 101);
    check("t3_next_col", int'(out_col), 4);
    tick();
    check("t3_wrap_data", int'(out_data), 108);
    check("t3_wrap_row", int'(out_row), 3);
    check("t3_wrap_col", int'(out_col), 0);
    run_out();

    // Overflow capture and a start during streaming.
    for (int k = 0; k < NUM_ELEMS; k++) mat[k*8 +: 8] = 8'(200 - k);
    matrix_flat = mat;
    overflow_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    overflow_in = 1'b0;
    repeat (6) tick();
    check("t4_row", int'(out_row), 1);
    check("t4_col", int'(out_col), 1);
    for (int k = 0; k < NUM_ELEMS; k++) mat[k*8 +: 8] = 8'hAA;
    matrix_flat = mat;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_ignored", int'(start_ignored), 1);
    check("t4_data_kept", int'(out_data), 193);
    check("t4_ovf", int'(out_overflow), 1);
    tick();
    check("t4_ignored_once", int'(start_ignored), 0);
    run_out();
    check("t4_ovf_hold", int'(out_overflow), 1);

    // Reset in the middle of a stream.
    for (int k = 0; k < NUM_ELEMS; k++) mat[k*8 +: 8] = 8'(k + 50);
    matrix_flat = mat;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (17) tick();
    check("t5_row", int'(out_row), 3);
    check("t5_col", int'(out_col), 2);
    check("t5_data", int'(out_data), 67);
    #1 reset_n = 1'b0;
    #1;
    check("t5_rst_valid", int'(out_valid), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_finished", int'(finished), 0);
    check("t5_rst_ovf", int'(out_overflow), 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("t5_idle", int'(out_valid), 0);
    for (int k = 0; k < NUM_ELEMS; k++) mat[k*8 +: 8] = 8'(k + 1);
    matrix_flat = mat;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_valid", int'(out_valid), 1);
    check("t5_restart_data", int'(out_data), 1);
    check("t5_restart_row", int'(out_row), 0);
    check("t5_restart_col", int'(out_col), 0);
    run_out();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 Parameter ROWS, 5, matrix row count.
REQ-002 Parameter COLS, 5, matrix column count.
REQ-003 Parameter ELEM_W, 8, signed element width in bits; MAT_W = ROWS*COLS*ELEM_W (200).
REQ-004 Port clock  input  1  sole clock, all state updates on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port start  input  1  single-cycle request to capture matrix_flat and begin streaming.
REQ-007 Port matrix_flat  input  MAT_W  signed row-major matrix; element (r,c) occupies bits r*COLS*ELEM_W + c*ELEM_W + ELEM_W-1 down to r*COLS*ELEM_W + c*ELEM_W.
REQ-008 Port overflow_in  input  1  overflow flag produced alongside matrix_flat.
REQ-009 Port out_ready  input  1  downstream accepts the current element.
REQ-010 Port out_valid  output  1  out_data holds a valid element.
REQ-011 Port out_data  output  ELEM_W  signed element value.
REQ-012 Port out_row  output  3  row index of out_data.
REQ-013 Port out_col  output  3  column index of out_data.
REQ-014 Port out_last  output  1  high with element (ROWS-1, COLS-1).
REQ-015 Port out_overflow  output  1  captured overflow_in, held for the whole stream.
REQ-016 Port busy  output  1  high from the cycle after capture until the final handshake.
REQ-017 Port finished  output  1  single-cycle pulse after the final handshake.
REQ-018 Port start_ignored  output  1  single-cycle pulse when start arrives while busy.

Function
REQ-019 States IDLE and SEND; IDLE->SEND on start in IDLE; SEND->IDLE on the handshake of out_last.
REQ-020 In IDLE with start=1: matrix_flat and overflow_in latch into a shadow register; row/col indices clear to 0.
REQ-021 Latency: start sampled at edge N yields out_valid=1 with element (0,0) after edge N, i.e. in cycle N+1.
REQ-022 In SEND: out_valid=1; out_data, out_row, out_col select the shadow element at the current indices.
REQ-023 Handshake occurs when out_valid and out_ready are both 1 at a rising edge; col increments, wrapping to 0 with row increment at col=COLS-1.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last hold stable.
REQ-025 With out_ready held at 1, all 25 elements stream in 25 consecutive cycles with no bubbles.
REQ-026 Handshake of out_last: next cycle state=IDLE, out_valid=0, busy=0, finished=1.
REQ-027 start in the cycle finished=1 is accepted as a normal IDLE start.
REQ-028 start while in SEND: ignored, the shadow register is unchanged, start_ignored=1 in the next cycle.
REQ-029 matrix_flat/overflow_in changes after capture do not affect the stream.
REQ-030 out_data is the raw ELEM_W-bit two's-complement field; no sign extension or saturation.
REQ-031 out_overflow updates only on capture and holds its value until the next capture or reset.

Reset
REQ-032 reset_n=0 forces state IDLE, indices 0, shadow register 0, and all outputs 0 immediately, independent of clock.
REQ-033 Reset mid-stream discards the remaining elements; finished is not pulsed.
REQ-034 The first start after reset deassertion is accepted normally.

Structure
REQ-035 Shared package holds ROWS, COLS, ELEM_W, MAT_W, index width and state encoding, for reuse by the multiplication ALU and its loaders.
REQ-036 One sub-module, matrix_element_select, implements the combinational (row,col)->element mux; the streamer holds all sequential logic.

Verification
REQ-037 matrix_flat with element (r,c) = r*5+c, start pulse, out_ready=1 -> values 0..24 in 25 consecutive cycles starting the cycle after start; out_last with 24; finished on the following cycle.
REQ-038 Element (0,0)=8'h80 and element (4,4)=8'h7F -> out_data -128 first and +127 last with out_last=1.
REQ-039 out_ready low for 3 cycles at element (2,3) -> out_data=(2,3), out_row=2, out_col=3 hold for 3 cycles; stream then resumes with (2,4), then wraps to (3,0).
REQ-040 start re-pulsed at element (1,1) with a different matrix_flat -> start_ignored pulses once; the stream continues with original values.
REQ-041 overflow_in=1 at capture, then 0 -> out_overflow=1 for all 25 elements.
REQ-042 reset_n low at element (3,2) -> out_valid, busy, finished all 0 at once; after release, a new start streams from (0,0).
